// File: rtl/phase_timer_if.sv
// Control/status bundle between a controller FSM and the phase_timer.
// The controller (master) issues load strobes and pause; the timer (slave) reports status.
interface phase_timer_if #(
    parameter int W = 32
);
    logic         next_state_flag;
    logic [W-1:0] state_time;
    logic         timer_pause;
    logic         state_done;
    logic         done_pulse;
    logic [W-1:0] remaining;
    logic         running;
    logic         paused;

    modport master (
        output next_state_flag, state_time, timer_pause,
        input  state_done, done_pulse, remaining, running, paused
    );

    modport slave (
        input  next_state_flag, state_time, timer_pause,
        output state_done, done_pulse, remaining, running, paused
    );
endinterface

// File: rtl/phase_timer.sv
// Phase countdown timer with prescaler, pause and done strobe; all outputs are registered.
// Controller FSMs load a phase duration and watch state_done / done_pulse.
module phase_timer #(
    parameter int TICK_DIV = 1,
    parameter int W        = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    phase_timer_if.slave    bus,
    output logic [1:0]      o_dbg_state
);
    // Load protocol: next_state_flag is a strobe sampled on every rising edge with no
    // back-pressure; state_time is only looked at when the strobe is high. A load always
    // wins over pause and expiry in the same cycle.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [15:0] PRE_MAX = 16'(TICK_DIV - 1);

    state_t       r_state,     w_state_nxt;
    logic [W-1:0] r_remaining, w_rem_nxt;
    logic [15:0]  r_prescale,  w_pre_nxt;
    logic         r_done,      w_done_nxt;
    logic         r_pulse,     w_pulse_nxt;
    logic         r_running,   w_running_nxt;
    logic         r_paused,    w_paused_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_prescale  <= '0;
            r_done      <= 1'b0;
            r_pulse     <= 1'b0;
            r_running   <= 1'b0;
            r_paused    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_rem_nxt;
            r_prescale  <= w_pre_nxt;
            r_done      <= w_done_nxt;
            r_pulse     <= w_pulse_nxt;
            r_running   <= w_running_nxt;
            r_paused    <= w_paused_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_remaining;
        w_pre_nxt   = r_prescale;
        w_done_nxt  = r_done;
        w_pulse_nxt = 1'b0;

        if (bus.next_state_flag) begin
            w_pre_nxt = '0;
            if (bus.state_time != '0) begin
                w_state_nxt = RUN;
                w_rem_nxt   = bus.state_time;
                w_done_nxt  = 1'b0;
            end else begin
                w_state_nxt = DONE;
                w_rem_nxt   = '0;
                w_done_nxt  = 1'b1;
                w_pulse_nxt = 1'b1;
            end
        end else begin
            case (r_state)
                IDLE: ;
                RUN: begin
                    if (bus.timer_pause) begin
                        w_state_nxt = PAUSED;
                    end else if (r_prescale >= PRE_MAX) begin
                        w_pre_nxt = '0;
                        // Expiry on the 1->0 decrement; the count saturates at zero.
                        if (r_remaining <= W'(1)) begin
                            w_rem_nxt   = '0;
                            w_state_nxt = DONE;
                            w_done_nxt  = 1'b1;
                            w_pulse_nxt = 1'b1;
                        end else begin
                            w_rem_nxt = r_remaining - W'(1);
                        end
                    end else begin
                        w_pre_nxt = r_prescale + 16'd1;
                    end
                end
                PAUSED: begin
                    if (!bus.timer_pause) w_state_nxt = RUN;
                end
                DONE: begin
                    w_rem_nxt  = '0;
                    w_done_nxt = 1'b1;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_rem_nxt   = '0;
                    w_pre_nxt   = '0;
                    w_done_nxt  = 1'b0;
                end
            endcase
        end

        w_running_nxt = (w_state_nxt == RUN);
        w_paused_nxt  = (w_state_nxt == PAUSED);
    end

    assign bus.state_done = r_done;
    assign bus.done_pulse = r_pulse;
    assign bus.remaining  = r_remaining;
    assign bus.running    = r_running;
    assign bus.paused     = r_paused;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer: one instance at TICK_DIV=1 and one at TICK_DIV=3,
// both driven from the same control signals.
module tb_phase_timer;
    localparam int W = 32;
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSED = 2'd2, S_DONE = 2'd3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         t_flag = 1'b0;
    logic [W-1:0] t_time = '0;
    logic         t_pause = 1'b0;
    logic [1:0]   dbg1, dbg3;

    int n_checks = 0;
    int n_errors = 0;

    phase_timer_if #(.W(W)) bus1 ();
    phase_timer_if #(.W(W)) bus3 ();

    assign bus1.next_state_flag = t_flag;
    assign bus1.state_time      = t_time;
    assign bus1.timer_pause     = t_pause;
    assign bus3.next_state_flag = t_flag;
    assign bus3.state_time      = t_time;
    assign bus3.timer_pause     = t_pause;

    phase_timer #(.TICK_DIV(1), .W(W)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .o_dbg_state(dbg1)
    );
    phase_timer #(.TICK_DIV(3), .W(W)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3), .o_dbg_state(dbg3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] val);
        t_flag = 1'b1;
        t_time = val;
        tick();
        t_flag = 1'b0;
    endtask

    task automatic check_all_clear(input string tag);
        check({tag, "_rem1"},   bus1.remaining,  0);
        check({tag, "_done1"},  bus1.state_done, 0);
        check({tag, "_pulse1"}, bus1.done_pulse, 0);
        check({tag, "_run1"},   bus1.running,    0);
        check({tag, "_pau1"},   bus1.paused,     0);
        check({tag, "_st1"},    dbg1,            S_IDLE);
        check({tag, "_rem3"},   bus3.remaining,  0);
        check({tag, "_done3"},  bus3.state_done, 0);
    endtask

    initial begin
        int n;
        // reset state
        #2;
        check_all_clear("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // IDLE ignores pause
        t_pause = 1'b1;
        tick();
        check("idle_pause_st", dbg1, S_IDLE);
        check("idle_pause_p",  bus1.paused, 0);
        t_pause = 1'b0;

        // basic countdown of 5 at TICK_DIV=1
        load(5);
        check("cd_rem0", bus1.remaining, 5);
        check("cd_run0", bus1.running, 1);
        check("cd_done0", bus1.state_done, 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("cd_rem", bus1.remaining, 32'(5 - k));
            check("cd_done", bus1.state_done, (k == 5) ? 32'd1 : 32'd0);
            check("cd_pulse", bus1.done_pulse, (k == 5) ? 32'd1 : 32'd0);
            check("cd_run", bus1.running, (k == 5) ? 32'd0 : 32'd1);
        end
        tick();
        check("cd_pulse_once", bus1.done_pulse, 0);
        check("cd_done_hold", bus1.state_done, 1);
        check("cd_st_done", dbg1, S_DONE);

        // pause mid-run at remaining=6
        load(10);
        repeat (4) tick();
        check("pz_rem6", bus1.remaining, 6);
        t_pause = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("pz_hold", bus1.remaining, 6);
            check("pz_paused", bus1.paused, 1);
            check("pz_run", bus1.running, 0);
        end
        t_pause = 1'b0;
        tick();
        check("pz_resume", bus1.running, 1);
        check("pz_resume_rem", bus1.remaining, 6);
        n = 0;
        while (!bus1.state_done && n < 20) begin
            tick();
            n++;
        end
        check("pz_latency", 32'(9 + n), 15);

        // prescaler at TICK_DIV=3, load 2
        load(2);
        check("ps_rem0", bus3.remaining, 2);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("ps_rem", bus3.remaining, 32'(2 - k / 3));
            check("ps_done", bus3.state_done, (k == 6) ? 32'd1 : 32'd0);
        end

        // zero load, DONE ignores pause, reload during DONE
        load(0);
        check("z_done", bus1.state_done, 1);
        check("z_pulse", bus1.done_pulse, 1);
        check("z_rem", bus1.remaining, 0);
        t_pause = 1'b1;
        tick();
        check("z_pause_ign", dbg1, S_DONE);
        check("z_pulse_off", bus1.done_pulse, 0);
        t_pause = 1'b0;
        load(7);
        check("rl_done", bus1.state_done, 0);
        check("rl_rem", bus1.remaining, 7);
        check("rl_run", bus1.running, 1);

        // held load strobe keeps restarting the count
        t_flag = 1'b1;
        t_time = 3;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_rem", bus1.remaining, 3);
        end
        t_flag = 1'b0;

        // load + pause at the expiry edge
        load(2);
        tick();
        check("sim_rem1", bus1.remaining, 1);
        t_flag = 1'b1;
        t_time = 4;
        t_pause = 1'b1;
        tick();
        t_flag = 1'b0;
        check("sim_rem4", bus1.remaining, 4);
        check("sim_run", bus1.running, 1);
        check("sim_pulse", bus1.done_pulse, 0);
        check("sim_done", bus1.state_done, 0);
        tick();
        check("sim_paused", bus1.paused, 1);
        check("sim_hold", bus1.remaining, 4);
        t_pause = 1'b0;

        // async reset mid-count
        load(5);
        repeat (2) tick();
        check("ar_rem3", bus1.remaining, 3);
        #2 rst_n = 1'b0;
        #1;
        check_all_clear("ar");
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("ar_no_done", bus1.state_done, 0);
            check("ar_no_pulse", bus1.done_pulse, 0);
            check("ar_idle", dbg1, S_IDLE);
        end

        // first load after release is accepted
        load(1);
        check("ar_load", bus1.remaining, 1);
        tick();
        check("ar_expire", bus1.done_pulse, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/phase_timer.md
PHASE_TIMER -- requirements
Module: phase_timer

Interface
REQ-001 The module SHALL have parameter TICK_DIV, default 1, giving the number of clk cycles per count decrement; legal range 1..65535.
REQ-002 The module SHALL have parameter W, default 32, giving the counter width.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 next_state_flag  input  1  load strobe from the controller FSM; sampled every cycle.
REQ-006 state_time  input  W  phase duration in ticks; sampled only when next_state_flag=1.
REQ-007 timer_pause  input  1  level; freezes the countdown while high.
REQ-008 state_done  output  1  level; high from expiry until the next load.
REQ-009 done_pulse  output  1  single-cycle strobe in the first cycle state_done is high.
REQ-010 remaining  output  W  current count value, registered.
REQ-011 running  output  1  high in RUN only.
REQ-012 paused  output  1  high in PAUSED only.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, PAUSED and DONE, with all outputs registered.
REQ-014 In any state, next_state_flag=1 with state_time!=0 SHALL on the next edge set remaining=state_time, clear the prescaler to 0, clear state_done, and enter RUN.
- Load has priority over pause and expiry in the same cycle.
REQ-015 In any state, next_state_flag=1 with state_time=0 SHALL on the next edge set remaining=0, enter DONE, set state_done=1 and assert done_pulse for one cycle.
REQ-016 The prescaler in RUN without pause SHALL increment each cycle.
- On reaching TICK_DIV-1 it wraps to 0 and remaining decrements by 1.
- With TICK_DIV=1, remaining decrements every cycle.
REQ-017 The decrement from remaining=1 SHALL, on the same edge, set remaining=0, enter DONE and set state_done=1, with done_pulse high for exactly that cycle.
- Latency: a load of N with TICK_DIV=1 gives state_done high N cycles after the load edge.
REQ-018 RUN with timer_pause=1 and no load SHALL enter PAUSED on the next edge, with no decrement and no prescaler advance in that cycle.
REQ-019 PAUSED SHALL hold remaining and the prescaler unchanged.
- Returns to RUN on the edge after timer_pause is sampled low; counting resumes the following cycle.
- The prescaler phase is preserved across a pause.
REQ-020 DONE SHALL hold state_done=1 and remaining=0 until a load, and SHALL ignore timer_pause.
REQ-021 IDLE SHALL ignore timer_pause; only a load leaves IDLE.
REQ-022 remaining SHALL never wrap below 0.
REQ-023 next_state_flag held high for multiple cycles SHALL reload on every such cycle, so the count restarts from state_time while the flag stays high.
REQ-024 Unreachable state encodings SHALL return to IDLE on the next edge with all outputs cleared.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, remaining=0, prescaler=0, state_done=0, done_pulse=0, running=0 and paused=0, independent of clk.
REQ-026 Reset asserted mid-count SHALL discard the count, and no done_pulse SHALL be generated on reset release.
REQ-027 The first load SHALL be accepted on the first rising clk edge after rst_n deasserts.

Verification
REQ-028 Basic countdown, TICK_DIV=1: load state_time=5 -> remaining reads 5,4,3,2,1,0; state_done rises 5 cycles after the load edge; done_pulse is high 1 cycle; running falls.
REQ-029 Pause mid-run, TICK_DIV=1: load 10, pause for 4 cycles at remaining=6 -> remaining holds 6, paused=1; state_done rises 10+4+1 cycles after load, allowing 1 cycle to resume.
REQ-030 Prescaler, TICK_DIV=3: load 2 -> decrements every 3rd cycle; state_done rises 6 cycles after load.
REQ-031 Zero load and reload: load 0 -> state_done=1 next cycle; a load of 7 during DONE -> state_done=0 and remaining=7 next cycle.
REQ-032 Simultaneous events: load 4 with timer_pause=1 at the same edge as expiry -> RUN with remaining=4, no done_pulse, then PAUSED on the next edge.
REQ-033 Async reset: assert rst_n low at remaining=3 between clock edges -> all outputs clear immediately; after release there is no state_done until a new load.
